// File: rtl/subtrator_serial_ctrl.sv
// ============================================================================
//  Module   : subtrator_serial_ctrl
//  Purpose  : Bit-serial subtraction controller. Computes diff = a - b by
//             time-sharing one external 1-bit full-subtractor cell over WIDTH
//             cycles, LSB first. The borrow chain lives in a flop and the
//             difference is assembled in a shift register.
//  Ports    : clk, rst_n (async, active-low)
//             start, a, b          - request and operands (captured in IDLE)
//             fs_a, fs_b, fs_bin   - operand bits / borrow-in to shared cell
//             fs_d, fs_bout        - difference / borrow-out from shared cell
//             busy, done           - status; done is a one-cycle pulse
//             diff, borrow         - result, held until the next result
//             ovf                  - signed overflow (SUBTRATOR_OVF_EN only)
//  Options  : `define SUBTRATOR_OVF_EN adds the ovf output and sign flops.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module subtrator_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             fs_a,
    output logic             fs_b,
    output logic             fs_bin,
    input  logic             fs_d,
    input  logic             fs_bout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUBTRATOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIM  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_diff_sh;
    logic             r_bflop;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_diff_nxt;

    // Difference register as it will look after this edge's shift; on the
    // last RUN edge this is the complete result, so diff is loaded from it
    // directly and is valid in the same cycle done rises.
    assign w_diff_nxt = {fs_d, r_diff_sh[WIDTH-1:1]};
    assign w_last     = (r_cnt == C_LAST_BIT);

    assign diff   = r_diff;
    assign borrow = r_borrow;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode. Cell drive comes from registers only,
    // so the shared cell never sees a path from the asynchronous inputs.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        fs_a        = 1'b0;
        fs_b        = 1'b0;
        fs_bin      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                fs_a   = r_sa[0];
                fs_b   = r_sb[0];
                fs_bin = r_bflop;
                if (w_last) begin
                    w_state_nxt = ST_FIM;
                end
            end
            ST_FIM: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand shifters, borrow flop, bit counter, result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa      <= '0;
            r_sb      <= '0;
            r_diff_sh <= '0;
            r_bflop   <= 1'b0;
            r_cnt     <= '0;
            r_diff    <= '0;
            r_borrow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sa      <= a;
                r_sb      <= b;
                r_diff_sh <= '0;
                r_bflop   <= 1'b0;
                r_cnt     <= '0;
            end else if (r_state == ST_RUN) begin
                r_sa      <= {1'b0, r_sa[WIDTH-1:1]};
                r_sb      <= {1'b0, r_sb[WIDTH-1:1]};
                r_diff_sh <= w_diff_nxt;
                r_bflop   <= fs_bout;
                r_cnt     <= r_cnt + 1'b1;
                if (w_last) begin
                    r_diff   <= w_diff_nxt;
                    r_borrow <= fs_bout;
                end
            end
        end
    end

`ifdef SUBTRATOR_OVF_EN
    // Sign bits are shifted out of r_sa/r_sb during RUN, so keep copies.
    logic r_sign_a;
    logic r_sign_b;
    logic r_ovf;

    assign ovf = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign_a <= a[WIDTH-1];
                r_sign_b <= b[WIDTH-1];
            end else if ((r_state == ST_RUN) && w_last) begin
                r_ovf <= (r_sign_a != r_sign_b) && (w_diff_nxt[WIDTH-1] != r_sign_a);
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_subtrator_serial_ctrl.sv
// ============================================================================
//  Module   : tb_subtrator_serial_ctrl
//  Purpose  : Self-checking bench for subtrator_serial_ctrl (WIDTH=8). Models
//             the shared 1-bit full-subtractor cell; stimulus pushes expected
//             results into a queue and a monitor pops them on done.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subtrator_serial_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         fs_a, fs_b, fs_bin;
    logic         fs_d, fs_bout;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SUBTRATOR_OVF_EN
    logic         ovf;
`endif

    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    exp_t         sb[$];
    logic [W-1:0] hold_d = '0;
    logic         hold_b = 1'b0;
    logic         hold_o = 1'b0;

    subtrator_serial_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .fs_a    (fs_a),
        .fs_b    (fs_b),
        .fs_bin  (fs_bin),
        .fs_d    (fs_d),
        .fs_bout (fs_bout),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .borrow  (borrow)
`ifdef SUBTRATOR_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    // Shared full-subtractor cell
    assign fs_d    = fs_a ^ fs_b ^ fs_bin;
    assign fs_bout = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_bin);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("diff", 32'(diff), 32'(e.d));
                    check("borrow", 32'(borrow), 32'(e.bo));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
`ifdef SUBTRATOR_OVF_EN
                    check("ovf", 32'(ovf), 32'(e.ov));
                    hold_o = e.ov;
`endif
                    hold_d = e.d;
                    hold_b = e.bo;
                end
            end else begin
                check("diff_hold", 32'(diff), 32'(hold_d));
                check("borrow_hold", 32'(borrow), 32'(hold_b));
`ifdef SUBTRATOR_OVF_EN
                check("ovf_hold", 32'(ovf), 32'(hold_o));
`endif
            end
        end
    end

    // Call just after a clock edge with the DUT idle.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
        exp_t e;
        start = 1'b1;
        a     = ia;
        b     = ib;
        e.d   = ed;
        e.bo  = eb;
        e.ov  = eo;
        e.cyc = cyc + 1 + W;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_diff"}, 32'(diff), 0);
        check({tag, "_borrow"}, 32'(borrow), 0);
        check({tag, "_fs"}, 32'({fs_a, fs_b, fs_bin}), 0);
`ifdef SUBTRATOR_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 0);
`endif
    endtask

    // Directed vectors: a, b, diff, borrow, ovf
    logic [W-1:0] va  [6] = '{8'd5,  8'd0, 8'hFF, 8'h7F, 8'h80, 8'h10};
    logic [W-1:0] vb  [6] = '{8'd10, 8'd0, 8'h01, 8'hFF, 8'h01, 8'h01};
    logic [W-1:0] vd  [6] = '{8'hFB, 8'h00, 8'hFE, 8'h80, 8'h7F, 8'h0F};
    logic         vbo [6] = '{1'b1,  1'b0, 1'b0,  1'b1,  1'b0,  1'b0};
    logic         vov [6] = '{1'b0,  1'b0, 1'b0,  1'b1,  1'b1,  1'b0};

    initial begin
        int nb, nd, dpos;
        logic [W-1:0] fsb;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 100 - 37: latency, busy window and borrow ripple seen by the cell
        issue(8'd100, 8'd37, 8'd63, 1'b0, 1'b0);
        nb = 0; nd = 0; dpos = -1; fsb = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                nd++;
                dpos = i;
            end
            if (i < 8) fsb[i] = fs_bin;
        end
        check("busy_cycles", 32'(nb), 9);
        check("done_count", 32'(nd), 1);
        check("done_pos", 32'(dpos), 8);
        check("fs_bin_seq", 32'(fsb), 32'h7E);
        @(negedge clk);
        check("busy_after", 32'(busy), 0);
        drain();

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], vd[i], vbo[i], vov[i]);
            drain();
        end

        // start while busy is ignored
        issue(8'h3C, 8'h5A, 8'hE2, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; a = 8'h11; b = 8'h22;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 8'h99; b = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        repeat (12) @(posedge clk);
        #1;

        // Reset in RUN cycle 4 aborts the operation
        issue(8'h55, 8'h0F, 8'h46, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_abort", 32'(busy), 1);
        rst_n  = 1'b0;
        sb.delete();
        hold_d = '0;
        hold_b = 1'b0;
        hold_o = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(8'h55, 8'h0F, 8'h46, 1'b0, 1'b0);
        drain();

        // Back-to-back with start held high
        begin
            exp_t e;
            start = 1'b1; a = 8'd200; b = 8'd1;
            e.d = 8'd199; e.bo = 1'b0; e.ov = 1'b0; e.cyc = cyc + 1 + W;
            sb.push_back(e);
            @(posedge clk); #1;
            a = 8'd1; b = 8'd200;
            e.d = 8'd57; e.bo = 1'b1; e.ov = 1'b0; e.cyc = cyc + W + 2 + W;
            sb.push_back(e);
            repeat (W + 2) @(posedge clk);
            #1;
            start = 1'b0;
        end
        drain();
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/subtrator_serial_ctrl.md
Name: subtrator_serial_ctrl

Overview:
Bit-serial subtraction controller. It computes D = A - B by time-sharing one external 1-bit full-subtractor cell (subtratorcompleto-style) over WIDTH clock cycles. It sequences operand bits LSB-first, keeps the borrow chain in a flip-flop and assembles the difference in a shift register. It replaces the unrolled ripple chain wherever area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits (2..16)
CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
fs_a  output  1  to shared cell: current minuend bit
fs_b  output  1  to shared cell: current subtrahend bit
fs_bin  output  1  to shared cell: borrow-in
fs_d  input  1  from shared cell: difference bit (combinational)
fs_bout  input  1  from shared cell: borrow-out (combinational)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result becomes valid
diff  output  WIDTH  result A-B mod 2**WIDTH, held until next accepted start
borrow  output  1  final borrow (1 when A < B unsigned), held with diff

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, diff, borrow, fs_a, fs_b, fs_bin all 0; internal shift registers, borrow flop and counter cleared. Reset mid-operation aborts the operation and discards it, with no done pulse.
- States: IDLE, RUN, FIM.
- IDLE: busy=0. start=1 at an edge -> latch a into sa, b into sb, bflop=0, cnt=0, state=RUN. start=0 -> stay in IDLE, with diff/borrow unchanged.
- RUN: busy=1. fs_a=sa[0], fs_b=sb[0], fs_bin=bflop, all decoded combinationally from registers (no glitch-sensitive paths from inputs).
- Each RUN edge: sa, sb shift right; diff_sh shifts right with fs_d entering the MSB; bflop<=fs_bout; cnt<=cnt+1.
- When cnt==WIDTH-1 at the edge: state=FIM.
- FIM (one cycle): busy=1, done=1. diff<=diff_sh and borrow<=bflop are registered at the entry edge, so they are valid in the same cycle as done. Next edge -> IDLE.
- fs_a/fs_b/fs_bin are 0 outside RUN.
- Latency: start sampled at edge 0. RUN covers cycles 1..WIDTH. done is high in cycle WIDTH+1, i.e. 9 cycles for WIDTH=8. Minimum issue interval is WIDTH+2 cycles.
- start while busy (RUN or FIM) is ignored and not queued. start held high continuously re-issues with the operands present at the IDLE edge.
- a/b may change freely after the accepting edge.
- diff/borrow change only on the FIM entry edge or on reset.
- Arithmetic: unsigned modulo 2**WIDTH; borrow = (a < b).

Optional Feature:
SUBTRATOR_OVF_EN. When defined: extra output port ovf (1 bit), registered with diff. ovf = signed two's-complement overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]). It is computed from the latched operand sign bits, which must be saved at start. ovf resets to 0. When not defined: no ovf port, no sign-bit flops, and behaviour is otherwise identical.

Test Plan:
- a=100, b=37, start 1 cycle -> busy for 9 cycles; done in cycle 9 only; diff=63, borrow=0; fs_bin sequence equals the expected ripple borrows.
- a=5, b=10 -> diff=251 (0xFB), borrow=1. a=0, b=0 -> diff=0, borrow=0. a=0xFF, b=0x01 -> diff=0xFE, borrow=0.
- start pulsed at cycles 3 and 5 after an accepted start, with different a/b -> ignored; result matches the first operands; exactly one done pulse.
- rst_n low in RUN cycle 4 -> immediately IDLE; all outputs 0; no done; a new start after release gives a correct result.
- Back-to-back: start held high with a=200, b=1 then a=1, b=200 -> results 199/borrow 0 then 57/borrow 1; done pulses 10 cycles apart; diff stable between pulses.
- SUBTRATOR_OVF_EN defined: a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1. a=0x80, b=0x01 -> diff=0x7F, ovf=1. a=0x10, b=0x01 -> ovf=0.
